// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op codes, FSM states,
// request-bundle width and an operand magnitude helper.
package mdu_ctrl_pkg;

    localparam int MDU_OP_WD        = 3;
    localparam int EX_TO_MDU_BUS_WD = MDU_OP_WD + 64;

    localparam logic [MDU_OP_WD-1:0] MDU_OP_MULT  = 3'd0;
    localparam logic [MDU_OP_WD-1:0] MDU_OP_MULTU = 3'd1;
    localparam logic [MDU_OP_WD-1:0] MDU_OP_DIV   = 3'd2;
    localparam logic [MDU_OP_WD-1:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [MDU_OP_WD-1:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [MDU_OP_WD-1:0] MDU_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_RUN  = 2'd1,
        MDU_ST_FIX  = 2'd2
    } mdu_state_e;

    // Magnitude of a 32-bit operand; unsigned ops pass the value through.
    function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// One iteration of the shared 64-bit datapath: shift-add multiply step
// (accumulator shifts right) or restoring divide step (accumulator shifts left).
module mdu_shift_core
    import mdu_ctrl_pkg::*;
(
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] operand_i,
    output logic [63:0] acc_o
);

    logic [32:0] mul_sum;
    logic [32:0] div_top;
    logic [32:0] div_diff;

    // Divide keeps {remainder, dividend/quotient}; multiply keeps {partial, multiplier}.
    always_comb begin
        mul_sum  = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? operand_i : 32'd0)};
        div_top  = acc_i[63:31];
        div_diff = div_top - {1'b0, operand_i};
        acc_o    = {mul_sum, acc_i[31:1]};
        if (is_div_i) begin
            if (!div_diff[32]) begin
                acc_o = {div_diff[31:0], acc_i[30:0], 1'b1};
            end else begin
                acc_o = {div_top[31:0], acc_i[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller owning HI/LO and sequencing 32 shift iterations.
// Build option MDU_FAST_MUL_EN: single-cycle combinational multiply instead of the sequence.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [MDU_OP_WD-1:0] req_op,
    input  logic [31:0]          req_src1,
    input  logic [31:0]          req_src2,
    output logic                 req_ready,
    input  logic                 cancel,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    mdu_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        is_div_q;
    logic        neg_q;
    logic        neg_rem_q;
    logic        divz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic [EX_TO_MDU_BUS_WD-1:0] req_bus;
    logic [MDU_OP_WD-1:0]        op;
    logic [31:0]                 src1;
    logic [31:0]                 src2;
    logic                        accept;
    logic                        op_is_div;
    logic                        op_is_mul;
    logic                        op_signed;
    logic                        start_iter;
    logic [63:0]                 acc_d;
    logic [31:0]                 fix_hi_d;
    logic [31:0]                 fix_lo_d;
    logic [63:0]                 prod_fix;

    assign req_bus = {req_op, req_src1, req_src2};
    assign {op, src1, src2} = req_bus;

    assign req_ready = (state_q == MDU_ST_IDLE);
    assign busy      = (state_q != MDU_ST_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    assign accept    = req_valid && req_ready && !cancel;
    assign op_is_div = (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    assign op_is_mul = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    assign op_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);

`ifdef MDU_FAST_MUL_EN
    logic [32:0] fast_a;
    logic [32:0] fast_b;
    logic [63:0] fast_prod;

    assign fast_a     = {op_signed & src1[31], src1};
    assign fast_b     = {op_signed & src2[31], src2};
    assign fast_prod  = {{31{fast_a[32]}}, fast_a} * {{31{fast_b[32]}}, fast_b};
    assign start_iter = accept && op_is_div;
`else
    assign start_iter = accept && (op_is_div || op_is_mul);
`endif

    mdu_shift_core u_core (
        .is_div_i  (is_div_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (acc_d)
    );

    // Sign fix-up; a zero divisor leaves the all-ones quotient untouched, and the
    // remainder fix restores the original dividend in that case.
    always_comb begin
        prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
        fix_hi_d = prod_fix[63:32];
        fix_lo_d = prod_fix[31:0];
        if (is_div_q) begin
            fix_lo_d = (neg_q && !divz_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            fix_hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MDU_ST_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MDU_ST_IDLE: begin
                    if (start_iter) begin
                        state_q   <= MDU_ST_RUN;
                        cnt_q     <= 5'd0;
                        acc_q     <= {32'd0, mdu_abs(src1, op_signed)};
                        opnd_q    <= mdu_abs(src2, op_signed);
                        is_div_q  <= op_is_div;
                        neg_q     <= op_signed && (src1[31] ^ src2[31]);
                        neg_rem_q <= op_signed && src1[31];
                        divz_q    <= (src2 == 32'd0);
                    end else if (accept && op == MDU_OP_MTHI) begin
                        hi_q   <= src1;
                        done_q <= 1'b1;
                    end else if (accept && op == MDU_OP_MTLO) begin
                        lo_q   <= src1;
                        done_q <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                    end else if (accept && op_is_mul) begin
                        hi_q   <= fast_prod[63:32];
                        lo_q   <= fast_prod[31:0];
                        done_q <= 1'b1;
`endif
                    end
                end
                MDU_ST_RUN: begin
                    if (cancel) begin
                        state_q <= MDU_ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= MDU_ST_FIX;
                        end
                    end
                end
                MDU_ST_FIX: begin
                    state_q <= MDU_ST_IDLE;
                    if (!cancel) begin
                        hi_q   <= fix_hi_d;
                        lo_q   <= fix_lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= MDU_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; inputs driven and outputs sampled on negedge.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_src1 = 32'd0;
    logic [31:0] req_src2 = 32'd0;
    logic        req_ready;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_BUSY    = 0;
    localparam int MUL_DONE_AT = 1;
`else
    localparam int MUL_BUSY    = 33;
    localparam int MUL_DONE_AT = 34;
`endif

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_ready (req_ready),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request at the current negedge and observe 40 following cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_n, output int done_at,
                          output int hold_err, output int overlap);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        busy_n = 0; done_n = 0; done_at = 0; hold_err = 0; overlap = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (busy) begin
                busy_n++;
                if (hi !== h0 || lo !== l0) hold_err++;
            end
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
            if (done && busy) overlap++;
        end
        $display("op=%0d src1=0x%08h src2=0x%08h -> hi=0x%08h lo=0x%08h busy_cycles=%0d done_at=%0d",
                 op, a, b, hi, lo, busy_n, done_at);
    endtask

    task automatic iter_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int exp_busy, input int exp_done_at);
        int bn, dn, da, he, ov;
        run_op(op, a, b, bn, dn, da, he, ov);
        check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check_eq({tag, "_busy_cycles"}, 64'(bn), 64'(exp_busy));
        check_eq({tag, "_done_at"}, 64'(da), 64'(exp_done_at));
        check_eq({tag, "_done_count"}, 64'(dn), 64'(exp_done_at == 0 ? 0 : 1));
        check_eq({tag, "_hold"}, 64'(he), 64'd0);
        check_eq({tag, "_done_busy_overlap"}, 64'(ov), 64'd0);
    endtask

    initial begin
        int dn;
        int waited;
        logic [31:0] h0;
        logic [31:0] l0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_done", 64'(done), 64'd0);

        iter_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0000_0000, 0, 1);
        iter_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1);
        iter_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 34);
        iter_op("divu_by0", 3'd3, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 34);
        iter_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 34);
        iter_op("div_m9_by0", 3'd2, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 33, 34);
        iter_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, 34);
        iter_op("mult_m1_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001,
                MUL_BUSY, MUL_DONE_AT);
        iter_op("multu_ff_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
                MUL_BUSY, MUL_DONE_AT);
        iter_op("mult_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
                MUL_BUSY, MUL_DONE_AT);
        iter_op("op6_ignored", 3'd6, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);

        // Cancel DIVU during RUN at iteration 10.
        h0 = hi;
        l0 = lo;
        req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'hFFFF_0000; req_src2 = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        $display("cancel divu at iter 10 -> busy=%0d ready=%0d", busy, req_ready);
        check_eq("cancel_busy", 64'(busy), 64'd0);
        check_eq("cancel_ready", 64'(req_ready), 64'd1);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        check_eq("cancel_no_done", 64'(dn), 64'd0);
        check_eq("cancel_hi_kept", 64'(hi), 64'(h0));
        check_eq("cancel_lo_kept", 64'(lo), 64'(l0));

        // A request presented together with cancel must be dropped.
        req_valid = 1'b1; req_op = 3'd4; req_src1 = 32'hDEAD_BEEF; cancel = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; cancel = 1'b0;
        $display("mthi with cancel -> hi=0x%08h done=%0d busy=%0d", hi, done, busy);
        check_eq("cancel_req_hi", 64'(hi), 64'(h0));
        check_eq("cancel_req_done", 64'(done), 64'd0);
        check_eq("cancel_req_busy", 64'(busy), 64'd0);

        // Reset in the middle of a divide.
        req_valid = 1'b1; req_op = 3'd2; req_src1 = 32'd100; req_src2 = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("midrst_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("reset mid-div -> hi=0x%08h lo=0x%08h busy=%0d ready=%0d", hi, lo, busy, req_ready);
        check_eq("midrst_hi", 64'(hi), 64'd0);
        check_eq("midrst_lo", 64'(lo), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_ready", 64'(req_ready), 64'd1);
        check_eq("midrst_done", 64'(done), 64'd0);

        // New request issued in the cycle done is high.
        req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'd100; req_src2 = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0;
        while (!done && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("dc_done_seen", 64'(done), 64'd1);
        check_eq("dc_ready_in_done", 64'(req_ready), 64'd1);
        iter_op("dc_divu_15_4", 3'd3, 32'd15, 32'd4, 32'd3, 32'd3, 33, 34);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
